sdram_apb_arbiter: RTL

//   Two-requester APB arbiter placed in front of the SDRAM APB slave.

---
 rtl/sdram_apb_arbiter_if.sv | 29 ++
 rtl/sdram_apb_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/sdram_apb_arbiter_if.sv
// APB bundle shared by the arbiter's upstream requesters and its downstream port.
// master drives the request fields; slave returns completion, data and error.
interface sdram_apb_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   paddr;
    logic                psel;
    logic                penable;
    logic [2:0]          pprot;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic                pready;
    logic [DATA_W-1:0]   prdata;
    logic                pslverr;

    modport master (
        output paddr, psel, penable, pprot,
        output pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pprot,
        input  pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/sdram_apb_arbiter.sv
// Two-requester APB arbiter in front of the SDRAM APB slave.
// m0 = instruction fetch, m1 = load/store; one downstream transfer at a time.
module sdram_apb_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    sdram_apb_arbiter_if.slave  m0,
    sdram_apb_arbiter_if.slave  m1,
    sdram_apb_arbiter_if.master out
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic                grant;
    logic                last;
    logic                pick;
    logic                req_any;
    logic                done;
    logic                rdy0;
    logic                rdy1;

    logic [ADDR_W-1:0]   paddr_q;
    logic [2:0]          pprot_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W/8-1:0] pstrb_q;

    // Requester penable carries no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = m0.penable ^ m1.penable;

    assign req_any = m0.psel | m1.psel;

    always_comb begin
        pick = 1'b0;
        if (m0.psel && m1.psel) begin
            pick = RR_EN ? ~last : 1'b0;
        end else begin
            pick = m1.psel;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
            end
            ACCESS: begin
                if (out.pready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= 1'b0;
            last     <= 1'b1;
            paddr_q  <= '0;
            pprot_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_any) begin
                grant <= pick;
                if (pick) begin
                    paddr_q  <= m1.paddr;
                    pprot_q  <= m1.pprot;
                    pwrite_q <= m1.pwrite;
                    pwdata_q <= m1.pwdata;
                    pstrb_q  <= m1.pstrb;
                end else begin
                    paddr_q  <= m0.paddr;
                    pprot_q  <= m0.pprot;
                    pwrite_q <= m0.pwrite;
                    pwdata_q <= m0.pwdata;
                    pstrb_q  <= m0.pstrb;
                end
            end
            if (done) begin
                last <= grant;
            end
        end
    end

    assign done = (state == ACCESS) && out.pready;

    assign out.paddr   = paddr_q;
    assign out.pprot   = pprot_q;
    assign out.pwrite  = pwrite_q;
    assign out.pwdata  = pwdata_q;
    assign out.pstrb   = pstrb_q;
    assign out.psel    = (state == SETUP) || (state == ACCESS);
    assign out.penable = (state == ACCESS);

    // A granted requester that dropped psel has its completion discarded.
    assign rdy0 = done && !grant && m0.psel;
    assign rdy1 = done &&  grant && m1.psel;

    assign m0.pready  = rdy0;
    assign m0.prdata  = rdy0 ? out.prdata : '0;
    assign m0.pslverr = rdy0 & out.pslverr;

    assign m1.pready  = rdy1;
    assign m1.prdata  = rdy1 ? out.prdata : '0;
    assign m1.pslverr = rdy1 & out.pslverr;
endmodule
